// File: rtl/deint_sched_pkg.sv
// deint_sched shared definitions
// sizes, FSM state type and per-bank start offsets
package deint_sched_pkg;

  localparam int NBANK = 6;
  localparam int DEPTH = 1536;
  localparam int WIDTH = 12;
  localparam int AW    = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  // start offsets in sixths of DEPTH:
  // bank 0..5 -> 0,3,5,1,4,2 (0,768,1280,256,1024,512)
  localparam logic [5:0][2:0] OFF_MUL = {
    3'd2, 3'd4, 3'd1, 3'd5, 3'd3, 3'd0
  };

  function automatic int init_off(
    input int b,
    input int depth
  );
    int m;
    m = int'(OFF_MUL[b % 6]);
    return (m * (depth / 6)) % depth;
  endfunction

endpackage

// File: rtl/deint_sched_if.sv
// deint_sched stream + SRAM bus bundle
// master drives symbols, slave is the scheduler
interface deint_sched_if #(
  parameter int NBANK = deint_sched_pkg::NBANK,
  parameter int WIDTH = deint_sched_pkg::WIDTH,
  parameter int AW    = deint_sched_pkg::AW
);

  logic             in_valid;
  logic [WIDTH-1:0] din;
  logic             in_ready;
  logic [NBANK-1:0] sram_csn;
  logic             sram_wen;
  logic [AW-1:0]    sram_addr;
  logic [WIDTH-1:0] sram_din;
  logic [2:0]       out_sel;
  logic             out_valid;
  logic             busy;

  modport master (
    output in_valid,
    output din,
    input  in_ready,
    input  sram_csn,
    input  sram_wen,
    input  sram_addr,
    input  sram_din,
    input  out_sel,
    input  out_valid,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  din,
    output in_ready,
    output sram_csn,
    output sram_wen,
    output sram_addr,
    output sram_din,
    output out_sel,
    output out_valid,
    output busy
  );

endinterface

// File: rtl/deint_ptr_bank.sv
// per-bank write pointers and primed flags
// pointer of the selected bank advances and wraps
module deint_ptr_bank
  import deint_sched_pkg::*;
#(
  parameter int NBANK = deint_sched_pkg::NBANK,
  parameter int DEPTH = deint_sched_pkg::DEPTH,
  parameter int AW    = deint_sched_pkg::AW,
  parameter int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_adv,
  input  logic [BW-1:0] i_bank,
  output logic [AW-1:0] o_ptr,
  output logic          o_primed
);

  logic [AW-1:0]    r_ptr [NBANK];
  logic [NBANK-1:0] r_primed;
  logic             w_wrap;

  assign w_wrap   = (r_ptr[i_bank] == AW'(DEPTH - 1));
  assign o_ptr    = r_ptr[i_bank];
  assign o_primed = r_primed[i_bank];

  // load start offsets on reset/clear, else step selected bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBANK; i++)
        r_ptr[i] <= AW'(init_off(i, DEPTH));
      r_primed <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < NBANK; i++)
        r_ptr[i] <= AW'(init_off(i, DEPTH));
      r_primed <= '0;
    end else if (i_adv) begin
      if (w_wrap) begin
        r_ptr[i_bank]    <= '0;
        r_primed[i_bank] <= 1'b1;
      end else begin
        r_ptr[i_bank] <= r_ptr[i_bank] + AW'(1);
      end
    end
  end

endmodule

// File: rtl/deint_sched.sv
// deint_sched: read-then-write bank sequencer
// one symbol per RD/WR pair, banks visited round robin
module deint_sched
  import deint_sched_pkg::*;
#(
  parameter int NBANK = deint_sched_pkg::NBANK,
  parameter int DEPTH = deint_sched_pkg::DEPTH,
  parameter int WIDTH = deint_sched_pkg::WIDTH,
  parameter int AW    = deint_sched_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sync_clr,
  deint_sched_if.slave  bus
);

  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [BW-1:0]    r_bank;
  logic [WIDTH-1:0] r_din_q;
  logic [WIDTH-1:0] r_din_hold;
  logic [AW-1:0]    r_addr_hold;

  logic [AW-1:0]    w_ptr;
  logic             w_primed;
  logic             w_ready;
  logic             w_xfer;
  logic             w_adv;
  logic [NBANK-1:0] w_csn;
  logic             w_wen;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_sdin;
  logic             w_valid;

  // rst_n is active-high: ready only out of reset
  assign w_ready = ~rst_n & (r_state != S_RD);
  assign w_xfer  = bus.in_valid & w_ready;
  assign w_adv   = (r_state == S_WR) & ~sync_clr;

  deint_ptr_bank #(
    .NBANK (NBANK),
    .DEPTH (DEPTH),
    .AW    (AW),
    .BW    (BW)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst_n),
    .i_clr    (sync_clr),
    .i_adv    (w_adv),
    .i_bank   (r_bank),
    .o_ptr    (w_ptr),
    .o_primed (w_primed)
  );

  // state register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next state and SRAM/output decode
  always_comb begin
    w_next  = r_state;
    w_csn   = '1;
    w_wen   = 1'b1;
    w_addr  = r_addr_hold;
    w_sdin  = r_din_hold;
    w_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_next = w_xfer ? S_RD : S_IDLE;
      end
      S_RD: begin
        w_next        = S_WR;
        w_csn[r_bank] = 1'b0;
        w_addr        = w_ptr;
      end
      S_WR: begin
        w_next        = w_xfer ? S_RD : S_IDLE;
        w_csn[r_bank] = 1'b0;
        w_wen         = 1'b0;
        w_addr        = w_ptr;
        w_sdin        = r_din_q;
        w_valid       = w_primed;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (sync_clr) w_next = S_IDLE;
  end

  // bank index steps after each completed write
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      r_bank <= '0;
    else if (sync_clr)
      r_bank <= '0;
    else if (w_adv)
      r_bank <= (r_bank == BW'(NBANK - 1)) ?
                '0 : r_bank + BW'(1);
  end

  // capture accepted symbol
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      r_din_q <= '0;
    else if (w_xfer && !sync_clr)
      r_din_q <= bus.din;
  end

  // remember last bus values so IDLE holds them
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_addr_hold <= '0;
      r_din_hold  <= '0;
    end else begin
      if (r_state != S_IDLE) r_addr_hold <= w_ptr;
      if (r_state == S_WR)   r_din_hold  <= r_din_q;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.sram_csn  = w_csn;
  assign bus.sram_wen  = w_wen;
  assign bus.sram_addr = w_addr;
  assign bus.sram_din  = w_sdin;
  assign bus.out_sel   = 3'(r_bank);
  assign bus.out_valid = w_valid;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_deint_sched.sv
// tb_deint_sched: random stream vs behavioural model
// bench owns the SRAM banks and a per-bank history
module tb_deint_sched;
  import deint_sched_pkg::*;

  localparam int NSYM = NBANK * DEPTH + NBANK;

  logic clk;
  logic rst_n = 1'b1;
  logic sync_clr = 1'b0;

  deint_sched_if #(
    .NBANK (NBANK),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) bus ();

  deint_sched #(
    .NBANK (NBANK),
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_clr (sync_clr),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // bench SRAM banks, one-cycle read latency
  logic [WIDTH-1:0] mem [NBANK][DEPTH];
  logic [WIDTH-1:0] sdo [NBANK];
  int wr_count = 0;

  task automatic clear_mem();
    for (int b = 0; b < NBANK; b++) begin
      sdo[b] = '0;
      for (int a = 0; a < DEPTH; a++) mem[b][a] = '0;
    end
  endtask

  // behavioural model: counts writes per bank
  int m_phase = 0;
  int m_cnt [NBANK];
  int m_total = 0;
  logic [WIDTH-1:0] m_dq = '0;
  int m_last_addr = 0;
  logic [WIDTH-1:0] m_last_din = '0;
  logic [WIDTH-1:0] hist [NBANK][2048];

  function automatic int off_of(input int b);
    case (b)
      0: return 0;
      1: return 768;
      2: return 1280;
      3: return 256;
      4: return 1024;
      default: return 512;
    endcase
  endfunction

  function automatic int mptr(input int b);
    return (off_of(b) + m_cnt[b]) % DEPTH;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_total = 0;
    m_dq = '0;
    m_last_addr = 0;
    m_last_din = '0;
    for (int b = 0; b < NBANK; b++) m_cnt[b] = 0;
  endtask

  task automatic sram_step();
    int a;
    a = int'(bus.sram_addr);
    for (int b = 0; b < NBANK; b++) begin
      if (!bus.sram_csn[b] && a < DEPTH) begin
        if (!bus.sram_wen) begin
          mem[b][a] = bus.sram_din;
          wr_count++;
        end else begin
          sdo[b] = mem[b][a];
        end
      end
    end
  endtask

  task automatic model_step();
    int b;
    b = m_total % NBANK;
    if (m_phase != 0) m_last_addr = mptr(b);
    if (m_phase == 2) m_last_din = m_dq;
    if (sync_clr) begin
      m_phase = 0;
      m_total = 0;
      for (int k = 0; k < NBANK; k++) m_cnt[k] = 0;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      if (m_phase == 2) begin
        if (m_cnt[b] < 2048) hist[b][m_cnt[b]] = m_dq;
        m_cnt[b]++;
        m_total++;
      end
      if (bus.in_valid) begin
        m_phase = 1;
        m_dq = bus.din;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  initial begin
    for (int b = 0; b < NBANK; b++) m_cnt[b] = 0;
    forever begin
      @(posedge clk or posedge rst_n);
      if (rst_n) model_reset();
      else begin
        sram_step();
        model_step();
      end
    end
  end

  // compare DUT against model every cycle
  bit vcnt_en = 0;
  int vcnt = 0;
  int v0cnt = 0;
  logic [WIDTH-1:0] v0_data = '0;

  task automatic compare();
    int b;
    int n;
    logic [NBANK-1:0] ecsn;
    logic ev;
    logic [WIDTH-1:0] ed;
    b = m_total % NBANK;
    n = m_cnt[b];
    ecsn = '1;
    if (m_phase != 0) ecsn[b] = 1'b0;
    chk("csn", bus.sram_csn, ecsn);
    chk("wen", bus.sram_wen, m_phase != 2);
    chk("addr", bus.sram_addr,
        m_phase == 0 ? m_last_addr : mptr(b));
    if (m_phase != 1)
      chk("sdin", bus.sram_din,
          m_phase == 2 ? m_dq : m_last_din);
    chk("ready", bus.in_ready,
        !rst_n && m_phase != 1);
    chk("busy", bus.busy, m_phase != 0);
    if (m_phase == 2) chk("sel", bus.out_sel, b);
    ev = (m_phase == 2) && (n >= DEPTH - off_of(b));
    chk("valid", bus.out_valid, ev);
    if (ev) begin
      ed = (n >= DEPTH) ? hist[b][n - DEPTH] : '0;
      chk("data", sdo[b], ed);
    end
    if (vcnt_en && bus.out_valid) begin
      vcnt++;
      if (bus.out_sel == 3'd0) begin
        if (v0cnt == 0) v0_data = sdo[0];
        v0cnt++;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) compare();
  end

  // recorder for the back-to-back literal checks
  bit rec_on = 0;
  int rec_n = 0;
  logic [AW-1:0]    rec_addr [16];
  logic [NBANK-1:0] rec_csn  [16];
  logic             rec_wen  [16];
  logic             rec_rdy  [16];
  logic [WIDTH-1:0] rec_sdin [16];

  initial forever begin
    @(negedge clk);
    if (rec_on && rec_n < 16) begin
      rec_addr[rec_n] = bus.sram_addr;
      rec_csn[rec_n]  = bus.sram_csn;
      rec_wen[rec_n]  = bus.sram_wen;
      rec_rdy[rec_n]  = bus.in_ready;
      rec_sdin[rec_n] = bus.sram_din;
      rec_n++;
    end
  end

  // called and returns at posedge+1
  task automatic send(input logic [WIDTH-1:0] d);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.din = d;
    @(negedge clk);
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] sym0;
    int w0;
    sym0 = '0;
    bus.in_valid = 1'b0;
    bus.din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    clear_mem();
    @(negedge clk);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_csn", bus.sram_csn, 6'h3f);
    chk("rst_addr", bus.sram_addr, 0);
    chk("rst_valid", bus.out_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("idle_csn", bus.sram_csn, 6'h3f);
    chk("idle_valid", bus.out_valid, 0);
    chk("idle_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    rec_on = 1;
    for (int i = 0; i < 6; i++) send(WIDTH'(i + 1));
    repeat (2) @(posedge clk);
    #1 rec_on = 0;
    chk("b2b_addr_bank0", rec_addr[1], 0);
    chk("b2b_addr_bank1", rec_addr[3], 768);
    chk("b2b_addr_bank5", rec_addr[11], 512);
    chk("b2b_csn_bank5", rec_csn[11], 6'b011111);
    chk("b2b_wen_rd", rec_wen[1], 1);
    chk("b2b_wen_wr", rec_wen[2], 0);
    chk("b2b_sdin_wr", rec_sdin[2], 1);
    for (int i = 1; i <= 12; i++)
      chk("b2b_ready_toggle", rec_rdy[i], (i % 2) == 0);

    for (int i = 0; i < 4; i++) begin
      send(WIDTH'($urandom));
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("gap_busy", bus.busy, 0);
      chk("gap_csn", bus.sram_csn, 6'h3f);
      @(posedge clk);
      #1;
    end

    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mem();
    rst_n = 1'b0;
    vcnt_en = 1;
    for (int i = 0; i < NSYM; i++) begin
      d = WIDTH'($urandom);
      if (i == 0) sym0 = d;
      send(d);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1 vcnt_en = 0;
    chk("valid_total", vcnt, 3846);
    chk("valid_bank0", v0cnt, 1);
    chk("bank0_first_out", v0_data, sym0);

    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mem();
    rst_n = 1'b0;
    send(WIDTH'(12'h111));
    send(WIDTH'(12'h222));
    send(WIDTH'(12'h333));
    w0 = wr_count;
    sync_clr = 1'b1;
    @(posedge clk);
    #1 sync_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("clr_rd_nowrite", wr_count, w0);
    chk("clr_rd_idle", bus.busy, 0);
    @(posedge clk);
    #1;
    send(WIDTH'(12'h444));
    @(negedge clk);
    chk("clr_bank0_addr", bus.sram_addr, 0);
    chk("clr_bank0_csn", bus.sram_csn, 6'b111110);
    @(posedge clk);
    #1;
    send(WIDTH'(12'h555));
    @(posedge clk);
    #1;
    w0 = wr_count;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wr_csn", bus.sram_csn, 6'h3f);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    chk("rst_wr_nowrite", wr_count, w0);
    @(negedge clk);
    chk("rst_release_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send(WIDTH'(12'h666));
    @(negedge clk);
    chk("rst_bank0_addr", bus.sram_addr, 0);
    @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
